// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D cache-miss memory arbiter.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    // Default memory access latency in cycles (legal 1..15).
    localparam int DEFAULT_LATENCY = 4;

    // The latency down-counter only has to hold LATENCY-1, which is at most 14.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_XFER = 2'd1,
        D_XFER = 2'd2
    } arbState_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grantSel_t;

    // D wins when it is the only requester, or on a tie when I was served last.
    function automatic logic pickD(
        input logic      iReq,
        input logic      dReq,
        input grantSel_t lastGrant
    );
        return dReq && (!iReq || (lastGrant == GRANT_I));
    endfunction

    // Saturating increment for the 16-bit grant counters.
    function automatic logic [15:0] satInc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// Loadable down-counter that times one memory access and flags when it reaches zero.
// Latency: zero is a combinational decode of the registered count.
// Backpressure: none; a load takes priority over a decrement, and the count holds at zero.
//
// Ports:
//   clk, rst          clock and asynchronous active-low reset (count resets to 0)
//   load, loadVal     load loadVal on the next edge
//   en                decrement on the next edge (ignored while the count is 0)
//   zero              high while the count is 0
module lat_counter
    import mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache miss requests onto one shared memory port.
// Latency: request sampled in cycle 0 -> mem_en in cycle 1, done/rdata in cycle LATENCY.
// Backpressure: a requester holds req until its done pulse; ties alternate between ports.
//
// Ports:
//   clk, rst                        clock and asynchronous active-low reset
//   i_req, i_addr                   I-cache miss request (read only)
//   i_done, i_rdata                 I-side completion pulse and read data (held between dones)
//   d_req, d_wr, d_addr, d_wdata    D-cache miss request (read or write)
//   d_done, d_rdata                 D-side completion pulse and read data (writes leave it alone)
//   mem_en, mem_wr, mem_addr,
//   mem_wdata, mem_rdata            shared memory; mem_en/mem_wr pulse in the first transfer cycle
//   i_grant_cnt, d_grant_cnt        saturating per-port grant counters
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_done,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    output logic [15:0] d_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic [15:0] i_grant_cnt,
    output logic [15:0] d_grant_cnt
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    arbState_t   state;
    grantSel_t   lastGrant;
    logic        wrLatch;
    logic [15:0] iRdataHold;
    logic [15:0] dRdataHold;

    logic        arbOpen;
    logic        grantI;
    logic        grantD;
    logic        cntEn;
    logic        cntZero;

    lat_counter u_lat_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (grantI || grantD),
        .loadVal (LOAD_VAL),
        .en      (cntEn),
        .zero    (cntZero)
    );

    // Arbitration happens in IDLE and again in the done cycle of a transfer, so
    // a waiting port (or a still-asserted req) follows with no idle bubble. In
    // the done cycle lastGrant is the port just served, so a tie goes to the other.
    always_comb begin
        arbOpen = (state == IDLE) || cntZero;
        grantD  = arbOpen && pickD(i_req, d_req, lastGrant);
        grantI  = arbOpen && i_req && !grantD;
        cntEn   = (state != IDLE);
        i_done  = (state == I_XFER) && cntZero;
        d_done  = (state == D_XFER) && cntZero;
        // Read data passes straight through in the done cycle, then is held.
        i_rdata = i_done ? mem_rdata : iRdataHold;
        d_rdata = (d_done && !wrLatch) ? mem_rdata : dRdataHold;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            lastGrant   <= GRANT_I;
            wrLatch     <= 1'b0;
            mem_en      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            iRdataHold  <= '0;
            dRdataHold  <= '0;
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
        end else begin
            // Strobes are high only in the first cycle of a transfer.
            mem_en <= grantI || grantD;
            mem_wr <= grantD && d_wr;

            if (grantD) begin
                state       <= D_XFER;
                lastGrant   <= GRANT_D;
                mem_addr    <= d_addr;
                mem_wdata   <= d_wdata;
                wrLatch     <= d_wr;
                d_grant_cnt <= satInc(d_grant_cnt);
            end else if (grantI) begin
                state       <= I_XFER;
                lastGrant   <= GRANT_I;
                mem_addr    <= i_addr;
                mem_wdata   <= '0;
                wrLatch     <= 1'b0;
                i_grant_cnt <= satInc(i_grant_cnt);
            end else if (arbOpen) begin
                state <= IDLE;
            end

            if (i_done) begin
                iRdataHold <= mem_rdata;
            end
            if (d_done && !wrLatch) begin
                dRdataHold <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    typedef struct {
        bit          isD;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    // DUT with default latency
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_done, d_done, mem_en, mem_wr;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] i_grant_cnt, d_grant_cnt;

    // DUT with LATENCY=1
    logic        i_req1, d_req1, d_wr1;
    logic [15:0] i_addr1, d_addr1, d_wdata1;
    logic        i_done1, d_done1, mem_en1, mem_wr1;
    logic [15:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic [15:0] i_grant_cnt1, d_grant_cnt1;

    exp_t q4[$];
    exp_t q1[$];
    exp_t e4, e1;
    int   remI = 0, remD = 0, remD1 = 0;

    // Memory model: data is a fixed scramble of the address.
    function automatic logic [15:0] memFn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    assign mem_rdata  = memFn(mem_addr);
    assign mem_rdata1 = memFn(mem_addr1);

    mem_arbiter #(.LATENCY(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
    );

    mem_arbiter #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req1), .i_addr(i_addr1), .i_done(i_done1), .i_rdata(i_rdata1),
        .d_req(d_req1), .d_wr(d_wr1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_done(d_done1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
        .i_grant_cnt(i_grant_cnt1), .d_grant_cnt(d_grant_cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push4(input bit isD, input logic [15:0] rd, input int c);
        exp_t e;
        e.isD = isD; e.rdata = rd; e.cyc = c;
        q4.push_back(e);
    endtask

    task automatic push1(input logic [15:0] rd, input int c);
        exp_t e;
        e.isD = 1'b1; e.rdata = rd; e.cyc = c;
        q1.push_back(e);
    endtask

    // Advance to the negedge of cycle t (always moves at least one negedge).
    task automatic waitCycle(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic waitDrain(input int budget);
        for (int n = 0; n < budget && (q4.size() != 0 || q1.size() != 0); n++)
            @(negedge clk);
        checkEq("drain", 32'(q4.size() + q1.size()), 32'd0);
    endtask

    // Scoreboard for the LATENCY=4 DUT; requesters drop req in their done cycle
    // once their remaining-transfer count is used up.
    always @(negedge clk) begin
        if (i_done || d_done) begin
            checkEq("one_done", 32'(i_done) + 32'(d_done), 32'd1);
            if (q4.size() == 0) begin
                checkEq("spurious_done", 32'({i_done, d_done}), 32'd0);
            end else begin
                e4 = q4.pop_front();
                checkEq("done_port_d", 32'(d_done), 32'(e4.isD));
                checkEq("done_cycle", 32'(cyc), 32'(e4.cyc));
                if (e4.isD) checkEq("d_rdata", 32'(d_rdata), 32'(e4.rdata));
                else        checkEq("i_rdata", 32'(i_rdata), 32'(e4.rdata));
            end
            if (i_done) begin
                if (remI > 0) remI--;
                if (remI == 0) i_req = 1'b0;
            end
            if (d_done) begin
                if (remD > 0) remD--;
                if (remD == 0) d_req = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (i_done1 || d_done1) begin
            if (q1.size() == 0) begin
                checkEq("l1_spurious_done", 32'({i_done1, d_done1}), 32'd0);
            end else begin
                e1 = q1.pop_front();
                checkEq("l1_done_d", 32'(d_done1), 32'd1);
                checkEq("l1_done_cycle", 32'(cyc), 32'(e1.cyc));
                checkEq("l1_d_rdata", 32'(d_rdata1), 32'(e1.rdata));
            end
            if (d_done1) begin
                if (remD1 > 0) remD1--;
                if (remD1 == 0) d_req1 = 1'b0;
            end
        end
    end

    initial begin
        int c0;
        int wrCnt;
        rst = 1'b0;
        i_req = 0; d_req = 0; d_wr = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
        i_req1 = 0; d_req1 = 0; d_wr1 = 0; i_addr1 = 0; d_addr1 = 0; d_wdata1 = 0;

        // Reset state
        repeat (3) @(negedge clk);
        checkEq("rst_mem_en", 32'(mem_en), 32'd0);
        checkEq("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkEq("rst_i_grant_cnt", 32'(i_grant_cnt), 32'd0);
        checkEq("rst_d_grant_cnt", 32'(d_grant_cnt), 32'd0);
        checkEq("rst_dones", 32'({i_done, d_done, i_done1, d_done1}), 32'd0);
        checkEq("rst_rdata", 32'({i_rdata, d_rdata}), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single I read
        @(posedge clk); #1;
        c0 = cyc;
        i_req = 1; i_addr = 16'h0040; remI = 1;
        push4(1'b0, memFn(16'h0040), c0 + 4);
        waitCycle(c0);
        checkEq("a_en_c0", 32'(mem_en), 32'd0);
        waitCycle(c0 + 1);
        checkEq("a_en_c1", 32'(mem_en), 32'd1);
        checkEq("a_wr_c1", 32'(mem_wr), 32'd0);
        checkEq("a_addr_c1", 32'(mem_addr), 32'h0040);
        waitCycle(c0 + 2);
        checkEq("a_en_c2", 32'(mem_en), 32'd0);
        waitDrain(20);
        checkEq("a_i_grant_cnt", 32'(i_grant_cnt), 32'd1);
        checkEq("a_i_rdata_held", 32'(i_rdata), 32'(memFn(16'h0040)));

        // Simultaneous requests: D first, then I with no bubble
        @(posedge clk); #1;
        c0 = cyc;
        i_req = 1; i_addr = 16'h0100; remI = 1;
        d_req = 1; d_wr = 0; d_addr = 16'h0200; remD = 1;
        push4(1'b1, memFn(16'h0200), c0 + 4);
        push4(1'b0, memFn(16'h0100), c0 + 8);
        waitCycle(c0 + 1);
        checkEq("b_addr_c1", 32'(mem_addr), 32'h0200);
        waitCycle(c0 + 5);
        checkEq("b_en_c5", 32'(mem_en), 32'd1);
        checkEq("b_addr_c5", 32'(mem_addr), 32'h0100);
        waitDrain(30);
        checkEq("b_i_grant_cnt", 32'(i_grant_cnt), 32'd2);
        checkEq("b_d_grant_cnt", 32'(d_grant_cnt), 32'd1);

        // D write: one mem_wr pulse, d_rdata untouched
        @(posedge clk); #1;
        c0 = cyc;
        d_req = 1; d_wr = 1; d_addr = 16'h1000; d_wdata = 16'hBEEF; remD = 1;
        push4(1'b1, memFn(16'h0200), c0 + 4);
        wrCnt = 0;
        for (int k = 1; k <= 4; k++) begin
            waitCycle(c0 + k);
            wrCnt += int'(mem_wr);
            if (k == 1) begin
                checkEq("c_wr_c1", 32'(mem_wr), 32'd1);
                checkEq("c_wdata_c1", 32'(mem_wdata), 32'hBEEF);
                checkEq("c_addr_c1", 32'(mem_addr), 32'h1000);
            end
        end
        checkEq("c_wr_pulses", 32'(wrCnt), 32'd1);
        waitDrain(20);
        d_wr = 0;
        checkEq("c_d_rdata_kept", 32'(d_rdata), 32'(memFn(16'h0200)));

        // Fresh reset, then both ports request continuously for 20 transfers
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        i_req = 1; i_addr = 16'h0300; remI = 10;
        d_req = 1; d_addr = 16'h0400; remD = 10;
        for (int k = 0; k < 20; k++)
            push4((k % 2) == 0, memFn((k % 2) == 0 ? 16'h0400 : 16'h0300), c0 + 4 * (k + 1));
        waitDrain(120);
        checkEq("d_i_grant_cnt", 32'(i_grant_cnt), 32'd10);
        checkEq("d_d_grant_cnt", 32'(d_grant_cnt), 32'd10);

        // Reset in cycle 2 of a D transfer
        @(posedge clk); #1;
        c0 = cyc;
        d_req = 1; d_addr = 16'h2000; remD = 1;
        waitCycle(c0 + 2);
        rst = 1'b0;
        #1;
        checkEq("e_mem_addr", 32'(mem_addr), 32'd0);
        checkEq("e_mem_en_wr", 32'({mem_en, mem_wr}), 32'd0);
        checkEq("e_i_rdata", 32'(i_rdata), 32'd0);
        checkEq("e_d_rdata", 32'(d_rdata), 32'd0);
        checkEq("e_grant_cnts", 32'({i_grant_cnt, d_grant_cnt}), 32'd0);
        d_req = 0; remD = 0;
        @(negedge clk); rst = 1'b1;
        waitCycle(cyc + 8);
        checkEq("e_d_grant_after", 32'(d_grant_cnt), 32'd0);
        @(posedge clk); #1;
        c0 = cyc;
        i_req = 1; i_addr = 16'h3000; remI = 1;
        d_req = 1; d_addr = 16'h2222; remD = 1;
        push4(1'b1, memFn(16'h2222), c0 + 4);
        push4(1'b0, memFn(16'h3000), c0 + 8);
        waitDrain(30);
        checkEq("e_grant_cnts_after", 32'({i_grant_cnt, d_grant_cnt}), 32'h0001_0001);

        // LATENCY=1 back-to-back D reads
        @(posedge clk); #1;
        c0 = cyc;
        d_req1 = 1; d_addr1 = 16'h0500; remD1 = 6;
        for (int k = 1; k <= 6; k++) push1(memFn(16'h0500), c0 + k);
        for (int k = 1; k <= 6; k++) begin
            waitCycle(c0 + k);
            checkEq("f_en", 32'(mem_en1), 32'd1);
        end
        waitCycle(c0 + 7);
        checkEq("f_en_after", 32'(mem_en1), 32'd0);
        checkEq("f_done_after", 32'(d_done1), 32'd0);
        waitDrain(10);
        checkEq("f_d_grant_cnt", 32'(d_grant_cnt1), 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
